// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED pattern generator (off/on/blink/chase/bounce/breathe/count)
module led_pattern_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int PRESCALE = 50000,
  parameter int PERIOD_W = 16,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  typedef enum logic [2:0] {
    M_OFF, M_ON, M_BLINK, M_CHASE, M_BOUNCE, M_BREATHE, M_COUNT, M_RSVD
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] chase_q, chase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                pos_up_q, pos_up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_up_q, duty_up_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [PERIOD_W-1:0] eff_last;
  logic                step;

  assign tick = tick_q;
  assign led  = led_q;

  always_comb begin
    mode_d     = mode_q;
    period_d   = period_q;
    pre_cnt_d  = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    chase_d    = chase_q;
    pos_d      = pos_q;
    pos_up_d   = pos_up_q;
    duty_d     = duty_q;
    duty_up_d  = duty_up_q;
    cnt_d      = cnt_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    step       = 1'b0;
    eff_last   = (period_q == '0) ? '0 : period_q - 1'b1;

    // led reflects the state registered on the previous edge
    case (mode_q)
      M_ON:      led_d = '1;
      M_BLINK:   led_d = {NUM_LEDS{phase_q}};
      M_CHASE:   led_d = chase_q;
      M_BOUNCE:  led_d = NUM_LEDS'(1) << pos_q;
      M_BREATHE: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
      M_COUNT:   led_d = cnt_q;
      default:   led_d = '0;
    endcase

    if (tick_q) begin
      if (step_cnt_q == eff_last) begin
        step_cnt_d = '0;
        step       = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end

    // every pattern advances together; only the selected one is visible
    if (step) begin
      phase_d = ~phase_q;
      chase_d = (chase_q << 1) | (chase_q >> (NUM_LEDS - 1));
      cnt_d   = cnt_q + 1'b1;
      if (NUM_LEDS > 1) begin
        if (pos_up_q) begin
          pos_d = pos_q + 1'b1;
          if (pos_d == POS_LAST) pos_up_d = 1'b0;
        end else begin
          pos_d = pos_q - 1'b1;
          if (pos_d == '0) pos_up_d = 1'b1;
        end
      end
      if (duty_up_q) begin
        duty_d = duty_q + 1'b1;
        if (duty_d == DUTY_MAX) duty_up_d = 1'b0;
      end else begin
        duty_d = duty_q - 1'b1;
        if (duty_d == '0) duty_up_d = 1'b1;
      end
    end

    if (cfg_we) begin
      mode_d     = mode_t'(cfg_mode);
      period_d   = cfg_period;
      pre_cnt_d  = '0;
      step_cnt_d = '0;
      phase_d    = 1'b1;
      chase_d    = NUM_LEDS'(1);
      pos_d      = '0;
      pos_up_d   = 1'b1;
      duty_d     = '0;
      duty_up_d  = 1'b1;
      cnt_d      = '0;
    end

    tick_d = (pre_cnt_d == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= M_OFF;
      period_q   <= PERIOD_W'(1);
      pre_cnt_q  <= '0;
      tick_q     <= 1'b0;
      step_cnt_q <= '0;
      phase_q    <= 1'b1;
      chase_q    <= NUM_LEDS'(1);
      pos_q      <= '0;
      pos_up_q   <= 1'b1;
      duty_q     <= '0;
      duty_up_q  <= 1'b1;
      cnt_q      <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      period_q   <= period_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_q     <= tick_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      chase_q    <= chase_d;
      pos_q      <= pos_d;
      pos_up_q   <= pos_up_d;
      duty_q     <= duty_d;
      duty_up_q  <= duty_up_d;
      cnt_q      <= cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
    end
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised multi-channel LED pattern generator. It is the next generation of the single-output led_demo blinker. It drives NUM_LEDS outputs in one of seven runtime-selectable modes: off, on, blink, chase, bounce, breathe (PWM) and binary count. All timing derives from an internal prescaler tick. It sits between board-level control logic (or a register interface) and the LED pins.

Parameters:
NUM_LEDS, 4, number of LED outputs (≥1)
PRESCALE, 50000, clk cycles per tick (≥2)
PERIOD_W, 16, width of cfg_period
PWM_BITS, 8, PWM counter and duty width for breathe mode

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe; latches cfg_mode and cfg_period
cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 CHASE, 4 BOUNCE, 5 BREATHE, 6 COUNT, 7 reserved (acts as OFF)
cfg_period  in  PERIOD_W  ticks per pattern step; 0 is treated as 1
tick  out  1  one-cycle pulse every PRESCALE clks (debug/sync)
led  out  NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- Reset (rst=1 at posedge) clears:
  - mode=OFF, period=1, prescaler=0, step_cnt=0, pattern state to initial values
  - tick=0, led=0
  - Reset mid-pattern aborts immediately; no partial step survives.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick=1 in the cycle where pre_cnt==PRESCALE-1, registered with the count. PRESCALE clks between pulses.
- Step counter: on tick, if step_cnt==eff_period-1 then step_cnt←0 and the pattern advances ("step"); otherwise step_cnt++. eff_period = max(period,1).
- cfg_we at a posedge performs all of the following:
  - latches mode and period
  - clears pre_cnt and step_cnt
  - loads the pattern initial state
  - cfg_we has priority over a coincident tick or step; that step is discarded
  - cfg_we while rst=1 is ignored
- Mode initial state and step action:
  - OFF/reserved: led all 0; no state.
  - ON: led all 1.
  - BLINK: phase initial 1; step toggles phase; led = {NUM_LEDS{phase}}.
  - CHASE: one-hot, initial bit0. Step rotates left; MSB wraps to bit0.
  - BOUNCE: pos initial 0, dir up.
    - Up: pos++ until NUM_LEDS-1, then reverse.
    - Down: pos-- until 0, then reverse.
    - End LEDs are not repeated: sequence for 4 LEDs is 0,1,2,3,2,1,0,1…
    - led = one-hot(pos).
  - BREATHE: duty initial 0, dir up.
    - Step: duty±1. At 2^PWM_BITS-1 it reverses to down; at 0 it reverses to up. Endpoints are held one step only, never duplicated.
    - pwm_cnt is a free-running PWM_BITS counter, +1 every clk, not reset by cfg_we.
    - led all = (pwm_cnt < duty). duty=0 gives fully dark.
  - COUNT: cnt initial 0; step cnt+1 mod 2^NUM_LEDS; led = cnt.
- Latency: led is a registered function of the current state. A state change at edge E is visible on led at edge E+1. After cfg_we is sampled at edge E0, led shows the initial pattern from E1.
- NUM_LEDS=1:
  - CHASE and BOUNCE hold led=1.
  - COUNT toggles.
- Mode switch with no cfg_we change (cfg_mode wiggling) has no effect.
- Synthesis: no latches; all outputs registered; widths via $clog2 with minimum 1.

Test Plan:
Use PRESCALE=4, NUM_LEDS=4, PWM_BITS=4 throughout.
- Reset: hold rst for 3 clks during an active CHASE pattern, then release → led=0000 and tick=0 on the first edge after rst. tick first pulses 4 clks after release; mode is OFF.
- BLINK: cfg_we with mode=2, period=2 → led=1111 from E1 for 8 clks, then 0000 for 8 clks, repeating. tick period is 4 clks.
- CHASE/BOUNCE: mode=3, period=1 → led 0001,0010,0100,1000,0001, changing every 4 clks. Then mode=4, period=1 → 0001,0010,0100,1000,0100,0010,0001,0010.
- BREATHE: mode=5, period=1 → duty after 15 steps = 15, giving led duty 15/16 per 16-clk window. Next step gives duty 14; after 30 steps duty=0 and led stays 0.
- COUNT wrap and period 0: mode=6, period=0 → led 0000,0001,…,1111,0000, stepping every tick (period 0 behaves as 1).
- Collision: assert cfg_we (mode=3) in the same cycle tick=1 with step_cnt==period-1 → step discarded. led=0001 from next edge, and the next advance occurs exactly period×4 clks later.
